// File: rtl/arith_pkg.sv
// Shared encodings for the multi-cycle arithmetic unit: operation codes and
// controller states used by the top level and its adder/subtractor.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULU = 2'b10,
        OP_DIVU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/arith_addsub.sv
// Combinational WIDTH-bit adder/subtractor: z = a + (sub ? ~b : b) + sub.
// cout is the carry out of the WIDTH+1 bit sum (for subtraction, 1 = no
// borrow); ovf is two's-complement signed overflow of the same operation.
module arith_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] z_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] bEff;
    logic [WIDTH:0]   sum;

    assign bEff   = sub_i ? ~b_i : b_i;
    assign sum    = {1'b0, a_i} + {1'b0, bEff} + {{WIDTH{1'b0}}, sub_i};
    assign z_o    = sum[WIDTH-1:0];
    assign cout_o = sum[WIDTH];
    assign ovf_o  = (a_i[WIDTH-1] == bEff[WIDTH-1]) && (z_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/arith_multicycle.sv
// Execute-stage arithmetic unit: single-cycle ADD/SUB plus WIDTH-iteration
// unsigned shift-add multiply and restoring divide, with valid/ready
// handshakes on both sides. One shared adder serves every operation.
//
// Datapath registers:
//   hiQ  - product high word (MULU) / partial remainder (DIVU); result_hi
//   loQ  - multiplier shifting out, product low bits shifting in (MULU) /
//          dividend shifting out, quotient bits shifting in (DIVU); result
//   opndQ - the operand held constant during iteration (a for MULU, b for DIVU)
module arith_multicycle
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    op_e              opIn;
    logic [WIDTH-1:0] addA, addB, addZ;
    logic             addSub, addCout, addOvf;
    logic [WIDTH-1:0] runHi, runLo;
    logic             divKeep;

    assign opIn = op_e'(op);

    arith_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i   (addA),
        .b_i   (addB),
        .sub_i (addSub),
        .z_o   (addZ),
        .cout_o(addCout),
        .ovf_o (addOvf)
    );

    // Adder operand steering: raw inputs while idle, iteration step while running
    always_comb begin
        addA   = a;
        addB   = b;
        addSub = op[0];
        if (state_q == S_RUN) begin
            if (op_q == OP_MULU) begin
                addA   = hi_q;
                addB   = opnd_q;
                addSub = 1'b0;
            end else begin
                addA   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                addB   = opnd_q;
                addSub = 1'b1;
            end
        end
    end

    // One iteration of multiply or divide, computed from the current registers
    always_comb begin
        divKeep = hi_q[WIDTH-1] | addCout;
        if (op_q == OP_MULU) begin
            if (lo_q[0]) begin
                {runHi, runLo} = {addCout, addZ, lo_q[WIDTH-1:1]};
            end else begin
                {runHi, runLo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end else begin
            runHi = divKeep ? addZ : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            runLo = {lo_q[WIDTH-2:0], divKeep};
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next state: single-cycle ops and divide-by-zero skip RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (opIn == OP_MULU || (opIn == OP_DIVU && b != '0)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the controller state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Datapath next state: capture on accept, iterate in RUN, hold in DONE
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        opnd_d = opnd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = opIn;
                    cnt_d  = '0;
                    hi_d   = '0;
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                    zero_d = 1'b0;
                    unique case (opIn)
                        OP_ADD, OP_SUB: begin
                            lo_d   = addZ;
                            cout_d = addCout;
                            ovf_d  = addOvf;
                            zero_d = (addZ == '0);
                        end
                        OP_MULU: begin
                            opnd_d = a;
                            lo_d   = b;
                        end
                        OP_DIVU: begin
                            if (b == '0) begin
                                lo_d  = '1;
                                hi_d  = a;
                                ovf_d = 1'b1;
                            end else begin
                                opnd_d = b;
                                lo_d   = a;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                hi_d  = runHi;
                lo_d  = runLo;
                if (cnt_q == LAST_CNT) begin
                    cout_d = 1'b0;
                    ovf_d  = (op_q == OP_MULU) && (runHi != '0);
                    zero_d = (runLo == '0);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, cleared by reset so an aborted operation leaves nothing behind
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= OP_ADD;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign result    = lo_q;
    assign result_hi = hi_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_arith_multicycle.sv
// Bench for arith_multicycle (WIDTH=32): directed vectors with literal
// expectations, plus a reference model computing results with plain integer
// arithmetic and a cycle-level handshake timeline that is checked every cycle.
module tb_arith_multicycle;

    localparam int W = 32;
    localparam logic [1:0] C_ADD  = 2'd0;
    localparam logic [1:0] C_SUB  = 2'd1;
    localparam logic [1:0] C_MULU = 2'd2;
    localparam logic [1:0] C_DIVU = 2'd3;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t mExp;
    bit   mKnown = 0;
    bit   mBusy  = 0;
    bit   mClean = 0;
    int   mWait  = 0;

    arith_multicycle #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .result_hi(result_hi),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero),
        .busy     (busy)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic straight from the operation definitions
    function automatic exp_t refModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        r;
        logic [W:0]  s;
        logic [63:0] p;
        longint      sr;
        r.res = '0;
        r.hi  = '0;
        r.c   = 1'b0;
        r.v   = 1'b0;
        case (o)
            C_ADD: begin
                s     = {1'b0, x} + {1'b0, y};
                r.res = s[W-1:0];
                r.c   = s[W];
                sr    = longint'($signed(x)) + longint'($signed(y));
                r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            C_SUB: begin
                r.res = x - y;
                r.c   = (x >= y);
                sr    = longint'($signed(x)) - longint'($signed(y));
                r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            C_MULU: begin
                p     = {32'd0, x} * {32'd0, y};
                r.res = p[31:0];
                r.hi  = p[63:32];
                r.v   = (r.hi != '0);
            end
            default: begin
                if (y == '0) begin
                    r.res = '1;
                    r.hi  = x;
                    r.v   = 1'b1;
                end else begin
                    r.res = x / y;
                    r.hi  = x % y;
                end
            end
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Model timeline: accept when idle, count down the iteration latency, release on out_ready
    always @(posedge clk) begin
        if (rst) begin
            mKnown = 1;
            mBusy  = 0;
            mWait  = 0;
            mClean = 1;
        end else if (mKnown) begin
            if (!mBusy) begin
                if (in_valid) begin
                    mExp   = refModel(op, a, b);
                    mWait  = (op == C_MULU || (op == C_DIVU && b != '0)) ? W : 0;
                    mBusy  = 1;
                    mClean = 0;
                end
            end else if (mWait > 0) begin
                mWait--;
            end else if (out_ready) begin
                mBusy = 0;
            end
        end
    end

    // Every-cycle comparison of DUT against the model, away from the active edge
    always @(negedge clk) begin
        if (mKnown) begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !mBusy});
            checkOutput("busy", {31'd0, busy}, {31'd0, mBusy});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (mBusy && mWait == 0)});
            if (mBusy && mWait == 0) begin
                checkOutput("m_result", result, mExp.res);
                checkOutput("m_result_hi", result_hi, mExp.hi);
                checkOutput("m_cout", {31'd0, cout}, {31'd0, mExp.c});
                checkOutput("m_ovf", {31'd0, ovf}, {31'd0, mExp.v});
                checkOutput("m_zero", {31'd0, zero}, {31'd0, mExp.z});
            end
            if (mClean) begin
                checkOutput("rst_result", result, '0);
                checkOutput("rst_result_hi", result_hi, '0);
                checkOutput("rst_flags", {29'd0, cout, ovf, zero}, '0);
            end
        end
    end

    // Present one request, hold it until accepted, then scramble the operand lines
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checkOutput("accept_timeout", n, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = ~o;
        a        = ~x;
        b        = y ^ 32'h5A5A_A5A5;
    endtask

    task automatic waitResult(input int expLat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < expLat + 20);
        checkOutput("latency", n, expLat);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("drain_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'd0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);

        applyStimulus(C_ADD, 32'h7FFF_FFFF, 32'd1);
        waitResult(1);
        checkOutput("add_result", result, 32'h8000_0000);
        checkOutput("add_flags", {29'd0, cout, ovf, zero}, 32'b010);
        drain();

        applyStimulus(C_SUB, 32'd5, 32'd5);
        waitResult(1);
        checkOutput("sub_eq_result", result, 32'd0);
        checkOutput("sub_eq_flags", {29'd0, cout, ovf, zero}, 32'b101);
        drain();

        applyStimulus(C_SUB, 32'd3, 32'd5);
        waitResult(1);
        checkOutput("sub_lt_result", result, 32'hFFFF_FFFE);
        checkOutput("sub_lt_cout", {31'd0, cout}, 32'd0);
        drain();

        applyStimulus(C_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitResult(33);
        checkOutput("mul_result", result, 32'h0000_0001);
        checkOutput("mul_result_hi", result_hi, 32'hFFFF_FFFE);
        checkOutput("mul_ovf", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_result", result, 32'h0000_0001);
            checkOutput("bp_result_hi", result_hi, 32'hFFFF_FFFE);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        drain();

        applyStimulus(C_DIVU, 32'd100, 32'd7);
        waitResult(33);
        checkOutput("div_q", result, 32'd14);
        checkOutput("div_r", result_hi, 32'd2);
        checkOutput("div_ovf", {31'd0, ovf}, 32'd0);
        drain();

        applyStimulus(C_DIVU, 32'd9, 32'd0);
        waitResult(1);
        checkOutput("div0_q", result, 32'hFFFF_FFFF);
        checkOutput("div0_r", result_hi, 32'd9);
        checkOutput("div0_ovf", {31'd0, ovf}, 32'd1);
        drain();

        // Model-only vectors covering carries, signed overflow and small quotients
        applyStimulus(C_ADD, 32'hFFFF_FFFF, 32'd1);
        waitResult(1);
        drain();
        applyStimulus(C_SUB, 32'h8000_0000, 32'd1);
        waitResult(1);
        drain();
        applyStimulus(C_MULU, 32'h1234_5678, 32'h9ABC_DEF0);
        waitResult(33);
        drain();
        applyStimulus(C_MULU, 32'd0, 32'h1234_5678);
        waitResult(33);
        drain();
        applyStimulus(C_DIVU, 32'hFFFF_FFFF, 32'd3);
        waitResult(33);
        drain();
        applyStimulus(C_DIVU, 32'd5, 32'd7);
        waitResult(33);
        drain();
        applyStimulus(C_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        waitResult(33);
        drain();

        // Request held high while busy must be ignored, and no accept on the transfer edge
        @(negedge clk);
        in_valid = 1'b1;
        op       = C_MULU;
        a        = 32'd3;
        b        = 32'd5;
        @(posedge clk);
        #1;
        op = C_ADD;
        a  = 32'd1;
        b  = 32'd1;
        waitResult(33);
        checkOutput("hold_mul_result", result, 32'd15);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bubble_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(1);
        checkOutput("hold_add_result", result, 32'd2);
        drain();

        // Abort a multiply mid-iteration
        applyStimulus(C_MULU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_result_hi", result_hi, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);
        applyStimulus(C_ADD, 32'd2, 32'd3);
        waitResult(1);
        checkOutput("post_rst_add", result, 32'd5);
        drain();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
